// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one request at a time and buffers {pc, inst} in a 2-entry FIFO.
// Optional same-cycle response bypass into decode when YSYX22040228_IFU_BYPASS_EN is defined.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        id_stall,
  input  logic        jalr_pc_ena,
  input  logic [63:0] jalr_pc,
  output logic        inst_valid,
  output logic [63:0] pc_o,
  output logic [31:0] inst_o,
  output logic        if_stall_req
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic [63:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic handshake;
  logic resp_live;
  logic fifo_empty;
  logic bypass_hit;
  logic pop;
  logic pop_fifo;
  logic push;

  // Nothing is ever outstanding in REQ, so count alone gates issue.
  assign req_valid  = (state == REQ) && (count != FULL);
  assign req_addr   = fetch_pc;
  assign handshake  = req_valid && req_ready;
  assign resp_live  = (state == WAIT) && resp_valid && !jalr_pc_ena;
  assign fifo_empty = (count == 2'd0);

`ifdef YSYX22040228_IFU_BYPASS_EN
  assign bypass_hit = resp_live && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign inst_valid   = !fifo_empty || bypass_hit;
  assign if_stall_req = !inst_valid && !rst;
  assign pop          = inst_valid && !id_stall && !jalr_pc_ena;
  assign pop_fifo     = pop && !fifo_empty;
  // A bypassed response consumed by decode in the same cycle never enters the FIFO.
  assign push         = resp_live && !(bypass_hit && pop);

  always_comb begin
    pc_o   = '0;
    inst_o = '0;
    if (!fifo_empty) begin
      pc_o   = fifo_pc[rd_ptr];
      inst_o = fifo_inst[rd_ptr];
    end else if (bypass_hit) begin
      pc_o   = req_pc;
      inst_o = resp_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (handshake) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
            state    <= jalr_pc_ena ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (resp_valid)       state <= REQ;
          else if (jalr_pc_ena) state <= DROP;
        end
        DROP: if (resp_valid) state <= REQ;
        default: state <= IDLE;
      endcase

      if (jalr_pc_ena) begin
        fetch_pc <= {jalr_pc[63:2], 2'b00};
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= 2'd0;
      end else begin
        if (push)     wr_ptr <= ~wr_ptr;
        if (pop_fifo) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop_fifo};
      end
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= resp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, stall/fill, JALR redirects, mid-run reset, PC wrap, bypass.
module tb_ifu_fetch;

`ifdef YSYX22040228_IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        id_stall;
  logic        jalr_pc_ena;
  logic [63:0] jalr_pc;
  logic        inst_valid;
  logic [63:0] pc_o;
  logic [31:0] inst_o;
  logic        if_stall_req;

  int          n_checks;
  int          n_fail;

  // Memory model controls, driven only by the main sequence.
  int          lat;
  bit          auto_en;
  bit          inject;
  logic [31:0] inject_data;

  bit          pend;
  int          cnt;
  logic [63:0] pend_addr;

  ifu_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .id_stall    (id_stall),
    .jalr_pc_ena (jalr_pc_ena),
    .jalr_pc     (jalr_pc),
    .inst_valid  (inst_valid),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .if_stall_req(if_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: samples the handshake mid-cycle, answers `lat` cycles after the accepting edge.
  initial begin
    pend       = 1'b0;
    cnt        = 0;
    pend_addr  = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (auto_en && req_valid && req_ready) begin
        pend      = 1'b1;
        cnt       = lat;
        pend_addr = req_addr;
      end
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (inject) begin
        resp_valid = 1'b1;
        resp_data  = inject_data;
      end else if (pend) begin
        if (cnt == 0) begin
          resp_valid = 1'b1;
          resp_data  = mem_data(pend_addr);
          pend       = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    req_ready   = 1'b0;
    id_stall    = 1'b0;
    jalr_pc_ena = 1'b0;
    jalr_pc     = '0;
    lat         = 0;
    auto_en     = 1'b1;
    inject      = 1'b0;
    inject_data = '0;

    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_addr", req_addr, 64'h8000_0000);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_pc_o", pc_o, 64'd0);
    check("rst_inst_o", 64'(inst_o), 64'd0);
    check("rst_if_stall_req", 64'(if_stall_req), 64'd0);
    rst       = 1'b0;
    req_ready = 1'b1;
    id_stall  = 1'b1;

    @(negedge clk);  // first REQ after IDLE
    check("first_req_valid", 64'(req_valid), 64'd1);
    check("first_req_addr", req_addr, 64'h8000_0000);
    check("first_stall_req", 64'(if_stall_req), 64'd1);

    @(negedge clk);  // WAIT, response on the bus this cycle
    check("resp_cycle_inst_valid", 64'(inst_valid), 64'(BYP));
    check("resp_cycle_req_valid", 64'(req_valid), 64'd0);

    @(negedge clk);
    check("head0_inst_valid", 64'(inst_valid), 64'd1);
    check("head0_pc", pc_o, 64'h8000_0000);
    check("head0_inst", 64'(inst_o), 64'h25A5_0000);
    check("second_req_addr", req_addr, 64'h8000_0004);
    check("second_req_valid", 64'(req_valid), 64'd1);

    repeat (2) @(negedge clk);  // second response pushed, FIFO full
    check("full_req_valid", 64'(req_valid), 64'd0);
    check("full_head_pc", pc_o, 64'h8000_0000);
    repeat (3) begin
      @(negedge clk);
      check("full_hold_req_valid", 64'(req_valid), 64'd0);
    end
    id_stall = 1'b0;

    @(negedge clk);  // head popped
    check("pop1_pc", pc_o, 64'h8000_0004);
    check("pop1_inst", 64'(inst_o), 64'h25A5_0004);
    check("resume_req_valid", 64'(req_valid), 64'd1);
    check("resume_req_addr", req_addr, 64'h8000_0008);
    id_stall = 1'b1;
    lat      = 1;

    @(negedge clk);  // WAIT with response still one cycle away
    check("wait_inst_valid", 64'(inst_valid), 64'd1);
    check("wait_pc", pc_o, 64'h8000_0004);
    jalr_pc_ena = 1'b1;
    jalr_pc     = 64'h8000_1003;

    @(negedge clk);  // DROP, FIFO cleared
    jalr_pc_ena = 1'b0;
    lat         = 0;
    check("redir_inst_valid", 64'(inst_valid), 64'd0);
    check("redir_stall_req", 64'(if_stall_req), 64'd1);
    check("redir_req_valid", 64'(req_valid), 64'd0);

    @(negedge clk);  // stale response dropped, new request
    check("drop_inst_valid", 64'(inst_valid), 64'd0);
    check("redir_req_valid_new", 64'(req_valid), 64'd1);
    check("redir_req_addr", req_addr, 64'h8000_1000);

    @(negedge clk);
    check("redir_wait_stall_req", 64'(if_stall_req), 64'(!BYP));

    @(negedge clk);
    check("redir_head_valid", 64'(inst_valid), 64'd1);
    check("redir_head_pc", pc_o, 64'h8000_1000);
    check("redir_head_inst", 64'(inst_o), 64'h25A5_1000);
    check("redir_head_stall_req", 64'(if_stall_req), 64'd0);
    check("hs_redir_req_addr", req_addr, 64'h8000_1004);
    check("hs_redir_req_valid", 64'(req_valid), 64'd1);
    jalr_pc_ena = 1'b1;
    jalr_pc     = 64'h8000_2000;

    @(negedge clk);  // redirect coincided with handshake -> DROP
    jalr_pc_ena = 1'b0;
    check("hs_redir_inst_valid", 64'(inst_valid), 64'd0);
    check("hs_redir_req_valid_drop", 64'(req_valid), 64'd0);

    @(negedge clk);
    check("hs_drop_inst_valid", 64'(inst_valid), 64'd0);
    check("hs_target_req_valid", 64'(req_valid), 64'd1);
    check("hs_target_req_addr", req_addr, 64'h8000_2000);

    @(negedge clk);  // WAIT with response in flight: assert reset
    rst       = 1'b1;
    req_ready = 1'b0;
    #1;
    check("midrst_inst_valid", 64'(inst_valid), 64'd0);
    check("midrst_req_valid", 64'(req_valid), 64'd0);
    check("midrst_req_addr", req_addr, 64'h8000_0000);
    check("midrst_stall_req", 64'(if_stall_req), 64'd0);

    @(negedge clk);
    rst         = 1'b0;
    inject      = 1'b1;
    inject_data = 32'hDEAD_BEEF;

    @(negedge clk);  // orphan response on the bus now
    inject = 1'b0;
    check("postrst_req_valid", 64'(req_valid), 64'd1);
    check("postrst_req_addr", req_addr, 64'h8000_0000);
    check("postrst_inst_valid", 64'(inst_valid), 64'd0);

    @(negedge clk);
    check("orphan_inst_valid", 64'(inst_valid), 64'd0);
    check("orphan_stall_req", 64'(if_stall_req), 64'd1);
    jalr_pc_ena = 1'b1;
    jalr_pc     = 64'hFFFF_FFFF_FFFF_FFFF;

    @(negedge clk);
    jalr_pc_ena = 1'b0;
    check("wrap_req_valid", 64'(req_valid), 64'd1);
    check("wrap_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    @(negedge clk);
    check("wrap_addr_hold", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    req_ready = 1'b1;

    @(negedge clk);
    check("wrap_wait_req_valid", 64'(req_valid), 64'd0);

    @(negedge clk);
    check("wrap_head_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_head_inst", 64'(inst_o), 64'h5A5A_FFFC);
    check("wrap_next_addr", req_addr, 64'd0);
    check("wrap_next_req_valid", 64'(req_valid), 64'd1);
    req_ready = 1'b0;
    id_stall  = 1'b0;

    @(negedge clk);
    check("wrap_pop_inst_valid", 64'(inst_valid), 64'd0);
    auto_en   = 1'b0;
    req_ready = 1'b1;

    @(negedge clk);  // WAIT, response arrives next cycle
    check("byp_wait_req_valid", 64'(req_valid), 64'd0);
    req_ready   = 1'b0;
    inject      = 1'b1;
    inject_data = 32'h0000_0013;

    @(negedge clk);
    inject = 1'b0;
    check("byp_same_cycle_valid", 64'(inst_valid), 64'(BYP));
    check("byp_same_cycle_inst", 64'(inst_o), BYP ? 64'h13 : 64'h0);

    @(negedge clk);
    check("byp_next_valid", 64'(inst_valid), 64'(!BYP));
    check("byp_next_inst", 64'(inst_o), BYP ? 64'h0 : 64'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
